mux_key_table: RTL and testbench

//  Programmable key/data table that produces the packed `lut` bus consumed by MuxKey/MuxKeyWithDefault.
//  It also performs the inverse lookup: given a data value, it returns the key that maps to it.

---
 rtl/mux_key_table_pkg.sv | 14 +
 rtl/mux_key_table_if.sv | 37 +++
 rtl/mux_key_table_store.sv | 76 +++++++
 rtl/mux_key_table.sv | 115 +++++++++++
 tb/tb_mux_key_table.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_key_table_pkg.sv
// Shared types and helpers for the key/data table and its reverse-lookup engine.
package mux_key_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int pair_len(input int key_len, input int data_len);
    return key_len + data_len;
  endfunction

endpackage

// File: rtl/mux_key_table_if.sv
// Config-write, packed table output and reverse-lookup handshake bundle.
interface mux_key_table_if #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 2
);
  localparam int IDX_W    = $clog2(NR_KEY);
  localparam int PAIR_LEN = mux_key_pkg::pair_len(KEY_LEN, DATA_LEN);

  logic                         clr;
  logic                         wr_valid;
  logic                         wr_ready;
  logic [IDX_W-1:0]             wr_idx;
  logic [KEY_LEN-1:0]           wr_key;
  logic [DATA_LEN-1:0]          wr_data;
  logic [NR_KEY*PAIR_LEN-1:0]   lut;
  logic [NR_KEY-1:0]            entry_vld;
  logic                         lk_valid;
  logic                         lk_ready;
  logic [DATA_LEN-1:0]          lk_data;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic                         rsp_hit;
  logic [KEY_LEN-1:0]           rsp_key;
  logic [IDX_W-1:0]             rsp_idx;

  modport master (
    output clr, wr_valid, wr_idx, wr_key, wr_data, lk_valid, lk_data, rsp_ready,
    input  wr_ready, lut, entry_vld, lk_ready, rsp_valid, rsp_hit, rsp_key, rsp_idx
  );

  modport slave (
    input  clr, wr_valid, wr_idx, wr_key, wr_data, lk_valid, lk_data, rsp_ready,
    output wr_ready, lut, entry_vld, lk_ready, rsp_valid, rsp_hit, rsp_key, rsp_idx
  );

endinterface

// File: rtl/mux_key_table_store.sv
// Register file of key/data pairs with clear/write logic, packed lut output and a scan read port.
module mux_key_table_store
  import mux_key_pkg::*;
#(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 2,
  localparam int IDX_W    = $clog2(NR_KEY),
  localparam int PAIR_LEN = pair_len(KEY_LEN, DATA_LEN)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [KEY_LEN-1:0]         wr_key,
  input  logic [DATA_LEN-1:0]        wr_data,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [KEY_LEN-1:0]         rd_key,
  output logic [DATA_LEN-1:0]        rd_data,
  output logic                       rd_vld,
  output logic [NR_KEY*PAIR_LEN-1:0] lut,
  output logic [NR_KEY-1:0]          entry_vld
);

  logic [KEY_LEN-1:0]  key_arr  [NR_KEY];
  logic [DATA_LEN-1:0] data_arr [NR_KEY];

  genvar gi;
  generate
    for (gi = 0; gi < NR_KEY; gi++) begin : g_entry
      logic [KEY_LEN-1:0]  key_reg;
      logic [DATA_LEN-1:0] data_reg;
      logic                vld_reg;
      logic                sel;

      // Out-of-range indices match no entry, so such writes vanish without side effects.
      assign sel = wr_en && (int'(wr_idx) == gi);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          key_reg  <= '0;
          data_reg <= '0;
          vld_reg  <= 1'b0;
        end else if (clr) begin
          key_reg  <= '0;
          data_reg <= '0;
          vld_reg  <= 1'b0;
        end else if (sel) begin
          key_reg  <= wr_key;
          data_reg <= wr_data;
          vld_reg  <= 1'b1;
        end
      end

      assign key_arr[gi]                      = key_reg;
      assign data_arr[gi]                     = data_reg;
      assign entry_vld[gi]                    = vld_reg;
      assign lut[PAIR_LEN*gi +: PAIR_LEN]     = {key_reg, data_reg};
    end
  endgenerate

  always_comb begin
    rd_key  = '0;
    rd_data = '0;
    rd_vld  = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (int'(rd_idx) == i) begin
        rd_key  = key_arr[i];
        rd_data = data_arr[i];
        rd_vld  = entry_vld[i];
      end
    end
  end

endmodule

// File: rtl/mux_key_table.sv
// Programmable key/data table with a sequential reverse (data -> key) lookup, one entry per cycle.
module mux_key_table
  import mux_key_pkg::*;
#(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 2
) (
  input  logic          clk,
  input  logic          rst,
  mux_key_table_if.slave bus
);

  localparam int               IDX_W    = $clog2(NR_KEY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_KEY - 1);

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    scan_idx_reg, scan_idx_next;
  logic [DATA_LEN-1:0] lk_data_reg, lk_data_next;
  logic                rsp_hit_reg, rsp_hit_next;
  logic [KEY_LEN-1:0]  rsp_key_reg, rsp_key_next;
  logic [IDX_W-1:0]    rsp_idx_reg, rsp_idx_next;

  logic [KEY_LEN-1:0]  rd_key;
  logic [DATA_LEN-1:0] rd_data;
  logic                rd_vld;
  logic                scan_hit;

  // The scan reads the live table, so edits during a scan reach entries not yet visited.
  mux_key_table_store #(
    .NR_KEY  (NR_KEY),
    .KEY_LEN (KEY_LEN),
    .DATA_LEN(DATA_LEN)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.clr),
    .wr_en    (bus.wr_valid),
    .wr_idx   (bus.wr_idx),
    .wr_key   (bus.wr_key),
    .wr_data  (bus.wr_data),
    .rd_idx   (scan_idx_reg),
    .rd_key   (rd_key),
    .rd_data  (rd_data),
    .rd_vld   (rd_vld),
    .lut      (bus.lut),
    .entry_vld(bus.entry_vld)
  );

  assign scan_hit = rd_vld && (rd_data == lk_data_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      scan_idx_reg <= '0;
      lk_data_reg  <= '0;
      rsp_hit_reg  <= 1'b0;
      rsp_key_reg  <= '0;
      rsp_idx_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      scan_idx_reg <= scan_idx_next;
      lk_data_reg  <= lk_data_next;
      rsp_hit_reg  <= rsp_hit_next;
      rsp_key_reg  <= rsp_key_next;
      rsp_idx_reg  <= rsp_idx_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    scan_idx_next = scan_idx_reg;
    lk_data_next  = lk_data_reg;
    rsp_hit_next  = rsp_hit_reg;
    rsp_key_next  = rsp_key_reg;
    rsp_idx_next  = rsp_idx_reg;
    case (state_reg)
      IDLE: begin
        if (bus.lk_valid) begin
          lk_data_next  = bus.lk_data;
          scan_idx_next = '0;
          state_next    = SCAN;
        end
      end
      SCAN: begin
        // Scanning upward and stopping at the first match makes the lowest index win.
        if (scan_hit) begin
          rsp_hit_next = 1'b1;
          rsp_key_next = rd_key;
          rsp_idx_next = scan_idx_reg;
          state_next   = RESP;
        end else if (scan_idx_reg == LAST_IDX) begin
          rsp_hit_next = 1'b0;
          rsp_key_next = '0;
          rsp_idx_next = '0;
          state_next   = RESP;
        end else begin
          scan_idx_next = scan_idx_reg + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.wr_ready  = 1'b1;
  assign bus.lk_ready  = (state_reg == IDLE);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_hit   = rsp_hit_reg;
  assign bus.rsp_key   = rsp_key_reg;
  assign bus.rsp_idx   = rsp_idx_reg;

endmodule

// File: tb/tb_mux_key_table.sv
// Self-checking bench for mux_key_table: vector table, corner sequences and randomized traffic vs a table model.
module tb_mux_key_table;

  localparam int NR = 4;
  localparam int KL = 2;
  localparam int DL = 2;

  localparam int OP_WR  = 0;
  localparam int OP_LK  = 1;
  localparam int OP_CLR = 2;
  localparam int OP_CHK = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_key_table_if #(.NR_KEY(NR), .KEY_LEN(KL), .DATA_LEN(DL)) bus ();
  mux_key_table #(.NR_KEY(NR), .KEY_LEN(KL), .DATA_LEN(DL)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  mux_key_table_if #(.NR_KEY(6), .KEY_LEN(KL), .DATA_LEN(DL)) bus6 ();
  mux_key_table #(.NR_KEY(6), .KEY_LEN(KL), .DATA_LEN(DL)) dut6 (
    .clk(clk), .rst(rst), .bus(bus6)
  );

  typedef struct {
    int         op;
    logic [1:0] idx, key, data;
    bit         eh;
    logic [1:0] ek, ei;
    int         el;
    int         hold;
    logic [15:0] elut;
    logic [3:0]  evld;
  } vec_t;

  vec_t vecs[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural table model
  logic [1:0] m_key  [NR];
  logic [1:0] m_data [NR];
  logic [3:0] m_vld;

  function automatic vec_t mk(int op, int idx, int key, int data, int eh, int ek, int ei,
                              int el, int hold, int elut, int evld);
    vec_t v;
    v.op = op; v.idx = 2'(idx); v.key = 2'(key); v.data = 2'(data);
    v.eh = (eh != 0); v.ek = 2'(ek); v.ei = 2'(ei); v.el = el; v.hold = hold;
    v.elut = 16'(elut); v.evld = 4'(evld);
    return v;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < NR; i++) begin
      m_key[i] = '0;
      m_data[i] = '0;
    end
    m_vld = '0;
  endfunction

  function automatic logic [15:0] m_lut();
    logic [15:0] v = '0;
    for (int i = 0; i < NR; i++) v[i*4 +: 4] = {m_key[i], m_data[i]};
    return v;
  endfunction

  task automatic ref_lookup(input logic [1:0] d, output bit hit, output logic [1:0] key,
                            output logic [1:0] idx, output int lat);
    hit = 1'b0; key = '0; idx = '0; lat = NR + 1;
    for (int i = 0; i < NR; i++) begin
      if (!hit && m_vld[i] && m_data[i] == d) begin
        hit = 1'b1; key = m_key[i]; idx = 2'(i); lat = i + 2;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // All tasks start and end at a falling edge.
  task automatic do_write(input logic [1:0] i, input logic [1:0] k, input logic [1:0] d);
    chk("wr_ready", 32'(bus.wr_ready), 1);
    bus.wr_valid = 1'b1; bus.wr_idx = i; bus.wr_key = k; bus.wr_data = d;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    m_key[i] = k; m_data[i] = d; m_vld[i] = 1'b1;
    $display("write idx=%0d key=%0d data=%0d", i, k, d);
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    m_clear();
    $display("clear");
  endtask

  task automatic lookup(input string nm, input logic [1:0] d, input bit eh, input logic [1:0] ek,
                        input logic [1:0] ei, input int el, input int clr_at, input int hold);
    int cnt = 0;
    bit seen = 1'b0;
    chk({nm, ".lk_ready"}, 32'(bus.lk_ready), 1);
    bus.lk_valid = 1'b1; bus.lk_data = d;
    while (!seen && cnt < 20) begin
      @(negedge clk);
      cnt++;
      bus.lk_valid = 1'b0;
      bus.wr_valid = 1'b0;
      bus.clr = (cnt == clr_at);
      if (bus.rsp_valid) seen = 1'b1;
    end
    bus.clr = 1'b0;
    chk({nm, ".latency"}, 32'(cnt), 32'(el));
    chk({nm, ".hit"}, 32'(bus.rsp_hit), 32'(eh));
    chk({nm, ".key"}, 32'(bus.rsp_key), 32'(ek));
    chk({nm, ".idx"}, 32'(bus.rsp_idx), 32'(ei));
    $display("lookup %s data=%0d hit=%0d key=%0d idx=%0d lat=%0d", nm, d,
             bus.rsp_hit, bus.rsp_key, bus.rsp_idx, cnt);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, ".hold_valid"}, 32'(bus.rsp_valid), 1);
      chk({nm, ".hold_hit"}, 32'(bus.rsp_hit), 32'(eh));
      chk({nm, ".hold_key"}, 32'(bus.rsp_key), 32'(ek));
      chk({nm, ".hold_idx"}, 32'(bus.rsp_idx), 32'(ei));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({nm, ".rsp_done"}, 32'(bus.rsp_valid), 0);
    chk({nm, ".ready_again"}, 32'(bus.lk_ready), 1);
  endtask

  initial begin
    bit         rh;
    logic [1:0] rk, ri, rd;
    int         rl;

    bus.clr = 0; bus.wr_valid = 0; bus.wr_idx = '0; bus.wr_key = '0; bus.wr_data = '0;
    bus.lk_valid = 0; bus.lk_data = '0; bus.rsp_ready = 0;
    bus6.clr = 0; bus6.wr_valid = 0; bus6.wr_idx = '0; bus6.wr_key = '0; bus6.wr_data = '0;
    bus6.lk_valid = 0; bus6.lk_data = '0; bus6.rsp_ready = 0;
    m_clear();

    // Vector table; lut expectations are hand-packed with pair n at bits [4n+3:4n], key on top.
    vecs.push_back(mk(OP_WR, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_WR, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_WR, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_WR, 3, 3, 2, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_CHK, 0, 0, 0, 0, 0, 0, 0, 0, 'hE871, 'hF));
    vecs.push_back(mk(OP_LK, 0, 0, 0, 1, 2, 2, 4, 3, 0, 0));
    vecs.push_back(mk(OP_LK, 0, 0, 3, 1, 1, 1, 3, 0, 0, 0));
    vecs.push_back(mk(OP_LK, 0, 0, 1, 1, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(OP_LK, 0, 0, 2, 1, 3, 3, 5, 1, 0, 0));
    vecs.push_back(mk(OP_WR, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_WR, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_CHK, 0, 0, 0, 0, 0, 0, 0, 0, 'hF871, 'hF));
    vecs.push_back(mk(OP_LK, 0, 0, 3, 1, 1, 1, 3, 0, 0, 0));
    vecs.push_back(mk(OP_LK, 0, 0, 2, 0, 0, 0, 5, 0, 0, 0));
    vecs.push_back(mk(OP_CLR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_CHK, 0, 0, 0, 0, 0, 0, 0, 0, 'h0000, 'h0));
    vecs.push_back(mk(OP_LK, 0, 0, 3, 0, 0, 0, 5, 0, 0, 0));

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset.lut", 32'(bus.lut), 0);
    chk("reset.entry_vld", 32'(bus.entry_vld), 0);
    chk("reset.rsp_valid", 32'(bus.rsp_valid), 0);
    chk("reset.lk_ready", 32'(bus.lk_ready), 1);
    chk("reset.rsp_hit", 32'(bus.rsp_hit), 0);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_WR:  do_write(vecs[i].idx, vecs[i].key, vecs[i].data);
        OP_LK:  lookup($sformatf("vec%0d", i), vecs[i].data, vecs[i].eh, vecs[i].ek,
                       vecs[i].ei, vecs[i].el, 0, vecs[i].hold);
        OP_CLR: do_clr();
        default: begin
          chk($sformatf("vec%0d.lut", i), 32'(bus.lut), 32'(vecs[i].elut));
          chk($sformatf("vec%0d.entry_vld", i), 32'(bus.entry_vld), 32'(vecs[i].evld));
        end
      endcase
    end

    // Write and clr together: clr wins
    bus.clr = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_idx = 2'd0; bus.wr_key = 2'd3; bus.wr_data = 2'd3;
    @(negedge clk);
    bus.clr = 1'b0; bus.wr_valid = 1'b0;
    chk("wr_clr.entry_vld", 32'(bus.entry_vld), 0);
    chk("wr_clr.lut", 32'(bus.lut), 0);

    // Write accepted in the same cycle as the lookup is seen by the scan
    bus.wr_valid = 1'b1; bus.wr_idx = 2'd0; bus.wr_key = 2'd2; bus.wr_data = 2'd1;
    m_key[0] = 2'd2; m_data[0] = 2'd1; m_vld[0] = 1'b1;
    lookup("wr_and_lk", 2'd1, 1'b1, 2'd2, 2'd0, 2, 0, 0);

    // clr before the matching entry is reached -> miss
    do_write(2'd3, 2'd1, 2'd2);
    lookup("clr_mid_scan", 2'd2, 1'b0, 2'd0, 2'd0, 5, 2, 0);
    m_clear();
    chk("clr_mid_scan.entry_vld", 32'(bus.entry_vld), 0);

    // clr landing on the capture edge does not undo the hit
    do_write(2'd1, 2'd3, 2'd1);
    lookup("clr_after_hit", 2'd1, 1'b1, 2'd3, 2'd1, 3, 2, 0);
    m_clear();
    chk("clr_after_hit.entry_vld", 32'(bus.entry_vld), 0);

    // Out-of-range writes on a 6-entry build
    bus6.wr_valid = 1'b1; bus6.wr_idx = 3'd5; bus6.wr_key = 2'd1; bus6.wr_data = 2'd2;
    @(negedge clk);
    bus6.wr_valid = 1'b0;
    chk("nr6.idx5_lut", 32'(bus6.lut), 32'h60_0000);
    chk("nr6.idx5_vld", 32'(bus6.entry_vld), 32'h20);
    bus6.wr_valid = 1'b1; bus6.wr_idx = 3'd7; bus6.wr_key = 2'd3; bus6.wr_data = 2'd3;
    @(negedge clk);
    bus6.wr_idx = 3'd6;
    @(negedge clk);
    bus6.wr_valid = 1'b0;
    chk("nr6.drop_lut", 32'(bus6.lut), 32'h60_0000);
    chk("nr6.drop_vld", 32'(bus6.entry_vld), 32'h20);

    // Asynchronous reset in the middle of a scan
    do_write(2'd3, 2'd1, 2'd1);
    bus.lk_valid = 1'b1; bus.lk_data = 2'd2;
    @(negedge clk);
    bus.lk_valid = 1'b0;
    chk("arst.scanning", 32'(bus.lk_ready), 0);
    #2 rst = 1'b1;
    #1;
    chk("arst.rsp_valid", 32'(bus.rsp_valid), 0);
    chk("arst.lk_ready", 32'(bus.lk_ready), 1);
    chk("arst.entry_vld", 32'(bus.entry_vld), 0);
    #1 rst = 1'b0;
    m_clear();
    @(negedge clk);
    do_write(2'd2, 2'd3, 2'd2);
    lookup("post_rst", 2'd2, 1'b1, 2'd3, 2'd2, 4, 0, 0);

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      int r = int'($urandom_range(0, 9));
      if (r < 5) begin
        do_write(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        chk("rnd.lut", 32'(bus.lut), 32'(m_lut()));
        chk("rnd.entry_vld", 32'(bus.entry_vld), 32'(m_vld));
      end else if (r < 9) begin
        rd = 2'($urandom_range(0, 3));
        ref_lookup(rd, rh, rk, ri, rl);
        lookup($sformatf("rnd%0d", it), rd, rh, rk, ri, rl, 0, int'($urandom_range(0, 2)));
      end else begin
        do_clr();
        chk("rnd.clr_vld", 32'(bus.entry_vld), 0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
